exibidor_sequencia: RTL and testbench

Sequence presenter for the memory game: on a start pulse it reads the stored sequence out of the game memory, address 0 up to a given limit, and shows each entry on the LEDs for a fixed time followed by a blank gap. It is the output counterpart of the player-input path, in which the player enters the sequence and the datapath compares it against memory. It sits beside `fluxo_dados` and drives the memory address while the control unit is in its "show sequence" phase. The block owns the address during playback and releases it (address 0) when idle.

---
 rtl/exibidor_sequencia_pkg.sv | 17 +
 rtl/exibidor_sequencia_temporizador.sv | 36 +++
 rtl/exibidor_sequencia.sv | 128 ++++++++++++
 tb/tb_exibidor_sequencia.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/exibidor_sequencia_pkg.sv
// Shared state codes for the sequence presenter; the control unit debug
// display decodes the same values.
package exibidor_sequencia_pkg;

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    CARREGA = 4'h1,
    MOSTRA  = 4'h2,
    APAGA   = 4'h3,
    FIM     = 4'hF
  } estado_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/exibidor_sequencia_temporizador.sv
// Up-counter with synchronous clear and enable; fim flags when the count
// equals the run-time compare value supplied by the FSM.
module temporizador #(
  parameter int M = 4,
  parameter int W = $clog2(M) + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  input  logic [W-1:0] ultimo,
  output logic         fim
);

  logic [W-1:0] valor_q, valor_d;

  always_comb begin
    valor_d = valor_q;
    if (zera) begin
      valor_d = '0;
    end else if (conta) begin
      valor_d = (valor_q == W'(M - 1)) ? '0 : valor_q + W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign fim = (valor_q == ultimo);

endmodule

// File: rtl/exibidor_sequencia.sv
// Plays the stored sequence from address 0 to limite on the LEDs, each entry
// lit for TEMPO_LED cycles and then dark for TEMPO_PAUSA cycles.
//
// state   | meaning
// INICIAL | idle, address released (0), waiting for iniciar
// CARREGA | latch memory word into leds, clear timer
// MOSTRA  | entry lit for TEMPO_LED cycles
// APAGA   | dark gap for TEMPO_PAUSA cycles, then next address or FIM
// FIM     | one-cycle pronto, address back to 0
module exibidor_sequencia
  import exibidor_sequencia_pkg::*;
#(
  parameter int TEMPO_LED   = 1000,
  parameter int TEMPO_PAUSA = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  input  logic [3:0] dado_memoria,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int TMAX = max_int(TEMPO_LED, TEMPO_PAUSA);
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] ULT_LED   = TW'(TEMPO_LED - 1);
  localparam logic [TW-1:0] ULT_PAUSA = TW'(TEMPO_PAUSA - 1);

  estado_t    estado_q, estado_d;
  logic [3:0] endereco_q, endereco_d;
  logic [3:0] leds_q, leds_d;
  logic [3:0] limite_q, limite_d;
  logic       zera, conta, fim_tempo;
  logic [TW-1:0] ultimo;

  // One timer serves both phases; only the compare target changes.
  assign ultimo = (estado_q == MOSTRA) ? ULT_LED : ULT_PAUSA;

  temporizador #(
    .M (TMAX),
    .W (TW)
  ) u_temporizador (
    .clock  (clock),
    .reset  (reset),
    .zera   (zera),
    .conta  (conta),
    .ultimo (ultimo),
    .fim    (fim_tempo)
  );

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    leds_d     = leds_q;
    limite_d   = limite_q;
    zera       = 1'b0;
    conta      = 1'b0;
    unique case (estado_q)
      INICIAL: begin
        endereco_d = 4'd0;
        leds_d     = 4'd0;
        if (iniciar) begin
          limite_d = limite;
          estado_d = CARREGA;
        end
      end
      CARREGA: begin
        leds_d   = dado_memoria;
        zera     = 1'b1;
        estado_d = MOSTRA;
      end
      MOSTRA: begin
        conta = 1'b1;
        if (fim_tempo) begin
          leds_d   = 4'd0;
          zera     = 1'b1;
          estado_d = APAGA;
        end
      end
      APAGA: begin
        conta = 1'b1;
        if (fim_tempo) begin
          zera = 1'b1;
          if (endereco_q == limite_q) begin
            estado_d = FIM;
          end else begin
            endereco_d = endereco_q + 4'd1;
            estado_d   = CARREGA;
          end
        end
      end
      FIM: begin
        endereco_d = 4'd0;
        estado_d   = INICIAL;
      end
      default: begin
        endereco_d = 4'd0;
        leds_d     = 4'd0;
        estado_d   = INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= INICIAL;
      endereco_q <= 4'd0;
      leds_q     <= 4'd0;
      limite_q   <= 4'd0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      leds_q     <= leds_d;
      limite_q   <= limite_d;
    end
  end

  assign endereco  = endereco_q;
  assign leds      = leds_q;
  assign pronto    = (estado_q == FIM);
  assign exibindo  = (estado_q != INICIAL) && (estado_q != FIM);
  assign db_estado = estado_q;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Bench for exibidor_sequencia with TEMPO_LED=4, TEMPO_PAUSA=2 and a
// combinational ROM holding 1,2,4,8 repeating.
module tb_exibidor_sequencia;

  localparam int TL = 4;
  localparam int TP = 2;
  localparam int EC = 1 + TL + TP;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] adr;
    logic [3:0] led;
    logic       ex;
    logic       pr;
  } obs_t;

  typedef struct {
    logic [3:0] lim;
    bit         hold;
    bit         chg;
    int         exp_pronto;
    int         exp_entries;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] dado_memoria;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       exibindo;
  logic       pronto;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  exibidor_sequencia #(
    .TEMPO_LED   (TL),
    .TEMPO_PAUSA (TP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .limite       (limite),
    .dado_memoria (dado_memoria),
    .endereco     (endereco),
    .leds         (leds),
    .exibindo     (exibindo),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] mem(input logic [3:0] a);
    logic [3:0] r;
    r = 4'b0001 << a[1:0];
    return r;
  endfunction

  assign dado_memoria = mem(endereco);

  function automatic obs_t observed();
    obs_t o;
    o.st  = db_estado;
    o.adr = endereco;
    o.led = leds;
    o.ex  = exibindo;
    o.pr  = pronto;
    return o;
  endfunction

  // Expected outputs n cycles after the start edge (n=1 is the cycle right after it).
  function automatic obs_t model(input int n, input int f, input logic [3:0] lim, input bit hold);
    obs_t o;
    int e, p;
    o = '0;
    if (n < f) begin
      e = (n - 1) / EC;
      p = (n - 1) % EC;
      o.adr = 4'(e);
      o.ex  = 1'b1;
      if (p == 0) begin
        o.st = 4'h1;
      end else if (p <= TL) begin
        o.st  = 4'h2;
        o.led = mem(4'(e));
      end else begin
        o.st = 4'h3;
      end
    end else if (n == f) begin
      o.st  = 4'hF;
      o.adr = lim;
      o.pr  = 1'b1;
    end else if (n == f + 2 && hold) begin
      o.st = 4'h1;
      o.ex = 1'b1;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run(input vec_t v);
    int f, pronto_at, n_pronto, entries, lit;
    logic [3:0] prev;
    obs_t o, x;
    f = (int'(v.lim) + 1) * EC + 1;
    pronto_at = -1;
    n_pronto = 0;
    entries = 0;
    lit = 0;
    prev = 4'd0;
    limite  = v.lim;
    iniciar = 1'b1;
    for (int a = 0; a <= int'(v.lim); a++) exp_q.push_back(mem(4'(a)));
    for (int n = 1; n <= f + 2; n++) begin
      @(negedge clock);
      if (n == 1 && !v.hold) iniciar = 1'b0;
      if (v.chg && n == 5) limite = 4'd5;
      o = observed();
      x = model(n, f, v.lim, v.hold);
      chk($sformatf("cycle%0d_lim%0d", n, v.lim), 32'(o), 32'(x));
      if (leds != 4'd0) begin
        if (prev == 4'd0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra_entry: got leds %0h expected none", leds);
          end else begin
            chk("sb_led", 32'(leds), 32'(exp_q.pop_front()));
          end
          entries++;
        end
        lit++;
      end else if (prev != 4'd0) begin
        chk("lit_len", 32'(lit), 32'(TL));
        lit = 0;
      end
      prev = leds;
      if (pronto) begin
        n_pronto++;
        if (pronto_at < 0) pronto_at = n;
      end
    end
    chk($sformatf("pronto_at_lim%0d", v.lim), 32'(pronto_at), 32'(v.exp_pronto));
    chk("pronto_count", 32'(n_pronto), 32'd1);
    chk("entries", 32'(entries), 32'(v.exp_entries));
    chk("sb_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (v.hold) begin
      iniciar = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
    end
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{lim: 4'd2,  hold: 1'b0, chg: 1'b0, exp_pronto: 22,  exp_entries: 3};
    tbl[1] = '{lim: 4'd0,  hold: 1'b0, chg: 1'b0, exp_pronto: 8,   exp_entries: 1};
    tbl[2] = '{lim: 4'd15, hold: 1'b0, chg: 1'b0, exp_pronto: 113, exp_entries: 16};
    tbl[3] = '{lim: 4'd1,  hold: 1'b1, chg: 1'b1, exp_pronto: 15,  exp_entries: 2};
    tbl[4] = '{lim: 4'd3,  hold: 1'b0, chg: 1'b0, exp_pronto: 29,  exp_entries: 4};

    reset   = 1'b1;
    iniciar = 1'b0;
    limite  = 4'd0;
    repeat (2) @(negedge clock);
    chk("reset_state", 32'(observed()), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk($sformatf("idle%0d", i), 32'(observed()), 32'd0);
    end

    foreach (tbl[i]) run(tbl[i]);

    // Abort during MOSTRA of entry 1.
    limite  = 4'd2;
    iniciar = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clock);
      if (n == 1) iniciar = 1'b0;
    end
    chk("pre_abort_state", 32'(db_estado), 32'h2);
    chk("pre_abort_leds", 32'(leds), 32'h2);
    #2 reset = 1'b1;
    #1 chk("abort_async", 32'(observed()), 32'd0);
    repeat (3) begin
      @(negedge clock);
      chk("abort_hold", 32'(observed()), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("post_abort_idle", 32'(observed()), 32'd0);
    end
    run('{lim: 4'd0, hold: 1'b0, chg: 1'b0, exp_pronto: 8, exp_entries: 1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
